// File: rtl/player_bullet_pkg.sv
// Shared game types for sprite blocks: signed screen coordinates, RGB pixel
// triplet, bullet lifecycle states and the screen top limit.
package player_bullet_pkg;

  typedef logic signed [11:0] coord_t;

  // Element 0 is red, 1 is green, 2 is blue; a 24'hRRGGBB literal casts directly.
  typedef logic [0:2][7:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } bullet_state_e;

  localparam coord_t SCREEN_TOP = 12'sd0;

  // Half-open signed span test: lo <= pos < lo + len.
  function automatic logic in_span(input coord_t pos, input coord_t lo, input coord_t len);
    coord_t hi;
    hi = lo + len;
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/player_bullet_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous button, followed by a
// rising-edge detector. LEVEL_OUT=1 returns the synchronised level instead.
module player_bullet_sync_edge #(
  parameter bit LEVEL_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = LEVEL_OUT ? r_sync : (r_sync & ~r_prev);

endmodule

// File: rtl/player_bullet.sv
// player_bullet: launches a shot from the player on fire, moves it up once per
// frame, retires it on alien hit or top exit, and renders it for the pixel mux.
// Build option PLAYER_BULLET_AUTO_FIRE_EN: a held fire button re-launches after each cooldown.
module player_bullet
  import player_bullet_pkg::*;
#(
  parameter int          BULLET_W        = 2,
  parameter int          BULLET_H        = 8,
  parameter int          SPEED           = 8,
  parameter int          X_OFF           = 9,
  parameter int          COOLDOWN_FRAMES = 4,
  parameter logic [23:0] COLOR           = 24'hFFFF00
) (
  input  logic   pixel_clk,
  input  logic   rst,
  input  logic   fsync,
  input  logic   fire,
  input  coord_t player_x,
  input  coord_t player_y,
  input  logic   alien_hit,
  input  coord_t hpos,
  input  coord_t vpos,
  output coord_t bullet_x,
  output coord_t bullet_y,
  output logic   bullet_active,
  output rgb_t   pixel,
  output logic   active
);

  localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

`ifdef PLAYER_BULLET_AUTO_FIRE_EN
  localparam bit FIRE_LEVEL = 1'b1;
`else
  localparam bit FIRE_LEVEL = 1'b0;
`endif

  bullet_state_e    r_state;
  bullet_state_e    w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_pending;
  logic             w_pending_next;
  coord_t           r_bx;
  coord_t           w_bx_next;
  coord_t           r_by;
  coord_t           w_by_next;
  logic             r_bactive;
  logic             w_bactive_next;
  logic             r_active;
  rgb_t             r_pixel;

  logic             w_fire_req;
  coord_t           w_y_moved;
  logic             w_in_rect;

  player_bullet_sync_edge #(
    .LEVEL_OUT (FIRE_LEVEL)
  ) u_fire_sync (
    .clk     (pixel_clk),
    .rst_n   (rst),
    .i_async (fire),
    .o_pulse (w_fire_req)
  );

  assign w_y_moved = r_by - coord_t'(SPEED);

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_bx      <= '0;
      r_by      <= '0;
      r_bactive <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pending <= w_pending_next;
      r_bx      <= w_bx_next;
      r_by      <= w_by_next;
      r_bactive <= w_bactive_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pending_next = r_pending;
    w_bx_next      = r_bx;
    w_by_next      = r_by;
    w_bactive_next = r_bactive;

    case (r_state)
      IDLE: begin
        if (fsync && r_pending) begin
          w_bx_next      = player_x + coord_t'(X_OFF);
          w_by_next      = player_y - coord_t'(BULLET_H);
          w_bactive_next = 1'b1;
          w_pending_next = 1'b0;
          w_state_next   = FLYING;
        end else if (w_fire_req) begin
          w_pending_next = 1'b1;
        end
      end

      FLYING: begin
        // A hit outranks a same-cycle frame step, so the bullet never moves on its hit frame.
        if (alien_hit) begin
          w_bactive_next = 1'b0;
          w_cnt_next     = CNT_W'(COOLDOWN_FRAMES);
          w_state_next   = COOLDOWN;
        end else if (fsync) begin
          w_by_next = w_y_moved;
          if (w_y_moved < SCREEN_TOP) begin
            w_bactive_next = 1'b0;
            w_cnt_next     = CNT_W'(COOLDOWN_FRAMES);
            w_state_next   = COOLDOWN;
          end
        end
      end

      COOLDOWN: begin
        if (r_cnt == '0) begin
          w_state_next = IDLE;
        end else if (fsync) begin
          w_cnt_next = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = IDLE;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_in_rect = r_bactive
                   && in_span(hpos, r_bx, coord_t'(BULLET_W))
                   && in_span(vpos, r_by, coord_t'(BULLET_H));

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_pixel  <= '0;
    end else begin
      r_active <= w_in_rect;
      r_pixel  <= w_in_rect ? rgb_t'(COLOR) : rgb_t'(24'h000000);
    end
  end

  assign bullet_x      = r_bx;
  assign bullet_y      = r_by;
  assign bullet_active = r_bactive;
  assign active        = r_active;
  assign pixel         = r_pixel;

endmodule

// File: tb/tb_player_bullet.sv
// Bench for player_bullet: directed scenarios followed by randomized frames,
// every cycle compared against a frame-level behavioural model of the bullet.
module tb_player_bullet;

  localparam int          BW   = 2;
  localparam int          BH   = 8;
  localparam int          SPD  = 8;
  localparam int          XOFF = 9;
  localparam int          CD   = 4;
  localparam logic [23:0] COL  = 24'hFFFF00;

`ifdef PLAYER_BULLET_AUTO_FIRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic               pixel_clk = 1'b0;
  logic               rst;
  logic               fsync;
  logic               fire;
  logic               alien_hit;
  logic signed [11:0] player_x;
  logic signed [11:0] player_y;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic signed [11:0] bullet_x;
  logic signed [11:0] bullet_y;
  logic               bullet_active;
  logic               active;
  logic [23:0]        pixel;

  int n_checks = 0;
  int n_err    = 0;
  int n_launch = 0;
  bit prev_ba  = 1'b0;

  // Reference model: bullet in flight or cooling down, frames left, pending shot,
  // plus the three-cycle history of sampled fire values.
  bit       m_fly;
  bit       m_cooling;
  bit       m_pending;
  bit       m_act;
  int       m_bx;
  int       m_by;
  int       m_cool;
  bit [2:0] m_syn;

  player_bullet dut (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .fsync         (fsync),
    .fire          (fire),
    .player_x      (player_x),
    .player_y      (player_y),
    .alien_hit     (alien_hit),
    .hpos          (hpos),
    .vpos          (vpos),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .pixel         (pixel),
    .active        (active)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fly     = 1'b0;
    m_cooling = 1'b0;
    m_pending = 1'b0;
    m_act     = 1'b0;
    m_bx      = 0;
    m_by      = 0;
    m_cool    = 0;
    m_syn     = 3'b000;
  endtask

  task automatic model_retire();
    m_fly     = 1'b0;
    m_cooling = 1'b1;
    m_cool    = CD;
  endtask

  task automatic check_all();
    expect_eq("bullet_active", {31'd0, bullet_active}, {31'd0, m_fly});
    expect_eq("bullet_x", {20'd0, bullet_x}, {20'd0, 12'(m_bx)});
    expect_eq("bullet_y", {20'd0, bullet_y}, {20'd0, 12'(m_by)});
    expect_eq("active", {31'd0, active}, {31'd0, m_act});
    expect_eq("pixel", {8'd0, pixel}, {8'd0, (m_act ? COL : 24'd0)});
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit req;
    bit in_rect;
    @(posedge pixel_clk);
    if (!rst) begin
      model_reset();
    end else begin
      in_rect = m_fly
             && int'(hpos) >= m_bx && int'(hpos) < m_bx + BW
             && int'(vpos) >= m_by && int'(vpos) < m_by + BH;
      req   = AUTO ? m_syn[1] : (m_syn[1] && !m_syn[2]);
      m_syn = {m_syn[1:0], fire};
      if (m_fly) begin
        if (alien_hit) begin
          model_retire();
        end else if (fsync) begin
          m_by = m_by - SPD;
          if (m_by < 0) model_retire();
        end
      end else if (m_cooling) begin
        if (m_cool == 0) begin
          m_cooling = 1'b0;
        end else if (fsync) begin
          m_cool--;
          if (m_cool == 0) m_cooling = 1'b0;
        end
      end else begin
        if (fsync && m_pending) begin
          m_fly     = 1'b1;
          m_bx      = int'(player_x) + XOFF;
          m_by      = int'(player_y) - BH;
          m_pending = 1'b0;
        end else if (req) begin
          m_pending = 1'b1;
        end
      end
      m_act = in_rect;
    end
    #1;
    check_all();
    if (bullet_active && !prev_ba) n_launch++;
    prev_ba = bullet_active;
  endtask

  task automatic frame();
    repeat (5) step();
    fsync = 1'b1;
    step();
    fsync = 1'b0;
  endtask

  task automatic pulse_fire();
    fire = 1'b1;
    step();
    step();
    fire = 1'b0;
    repeat (3) step();
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 7) == 0) fire = ~fire;
    alien_hit = ($urandom_range(0, 24) == 0);
    if ($urandom_range(0, 15) == 0) begin
      player_x = 12'($urandom_range(0, 1900));
      player_y = 12'($urandom_range(8, 160));
    end
    if ($urandom_range(0, 1) == 1) begin
      hpos = 12'(m_bx + int'($urandom_range(0, 4)) - 1);
      vpos = 12'(m_by + int'($urandom_range(0, 11)) - 2);
    end else begin
      hpos = 12'($urandom_range(0, 2000));
      vpos = 12'($urandom_range(0, 2000));
    end
  endtask

  initial begin
    rst       = 1'b0;
    fsync     = 1'b0;
    fire      = 1'b0;
    alien_hit = 1'b0;
    player_x  = '0;
    player_y  = '0;
    hpos      = '0;
    vpos      = '0;
    model_reset();

    // Reset state, then three quiet frames.
    repeat (3) step();
    rst = 1'b1;
    repeat (3) frame();
    expect_eq("quiet_no_launch", {31'd0, bullet_active}, 32'd0);

    // Launch from (100,400) and one frame of travel, with a raster sweep in between.
    player_x = 12'sd100;
    player_y = 12'sd400;
    pulse_fire();
    frame();
    expect_eq("launch_active", {31'd0, bullet_active}, 32'd1);
    expect_eq("launch_x", {20'd0, bullet_x}, 32'd109);
    expect_eq("launch_y", {20'd0, bullet_y}, 32'd392);
    for (int h = 108; h <= 111; h++) begin
      for (int k = 0; k < 4; k++) begin
        int vlist[4] = '{391, 392, 399, 400};
        hpos = 12'(h);
        vpos = 12'(vlist[k]);
        step();
      end
    end
    hpos = 12'sd110;
    vpos = 12'sd399;
    step();
    expect_eq("raster_in_active", {31'd0, active}, 32'd1);
    expect_eq("raster_in_pixel", {8'd0, pixel}, 32'h00FFFF00);
    hpos = 12'sd111;
    step();
    expect_eq("raster_right_active", {31'd0, active}, 32'd0);
    expect_eq("raster_right_pixel", {8'd0, pixel}, 32'd0);
    hpos = '0;
    vpos = '0;
    frame();
    expect_eq("move_y", {20'd0, bullet_y}, 32'd384);

    // Hit coincident with a frame pulse: hit wins, no move.
    fsync     = 1'b1;
    alien_hit = 1'b1;
    step();
    fsync     = 1'b0;
    alien_hit = 1'b0;
    expect_eq("hit_retire", {31'd0, bullet_active}, 32'd0);
    expect_eq("hit_hold_y", {20'd0, bullet_y}, 32'd384);
    repeat (CD) frame();

    // Launch near the top, leave the screen, then cooldown gating of re-fire.
    player_y = 12'sd20;
    pulse_fire();
    frame();
    expect_eq("top_launch_y", {20'd0, bullet_y}, 32'd12);
    frame();
    frame();
    expect_eq("top_exit_retire", {31'd0, bullet_active}, 32'd0);
    pulse_fire();
    repeat (CD) frame();
    frame();
    expect_eq("cooldown_drop_fire", {31'd0, bullet_active}, 32'd0);
    pulse_fire();
    frame();
    expect_eq("relaunch", {31'd0, bullet_active}, 32'd1);

    // Asynchronous reset between clock edges while in flight.
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    expect_eq("async_rst_active", {31'd0, bullet_active}, 32'd0);
    expect_eq("async_rst_y", {20'd0, bullet_y}, 32'd0);
    step();
    step();
    rst = 1'b1;
    pulse_fire();
    frame();
    expect_eq("post_reset_launch", {31'd0, bullet_active}, 32'd1);

    // Held fire button across many frames.
    alien_hit = 1'b1;
    step();
    alien_hit = 1'b0;
    repeat (CD + 1) frame();
    n_launch = 0;
    fire = 1'b1;
    repeat (20) frame();
    fire = 1'b0;
`ifdef PLAYER_BULLET_AUTO_FIRE_EN
    expect_eq("autofire_relaunch", {31'd0, (n_launch >= 2)}, 32'd1);
`else
    expect_eq("held_fire_single_shot", n_launch, 32'd1);
`endif

    // Randomized frames of variable length.
    for (int f = 0; f < 250; f++) begin
      int gap;
      gap = int'($urandom_range(2, 7));
      for (int c = 0; c < gap; c++) begin
        rand_inputs();
        step();
      end
      rand_inputs();
      fsync = 1'b1;
      step();
      fsync = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
